// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake; optional iterative MULTU under `ALU_MUL_EN.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MULTU.
// Backpressure: result held while out_ready is low; in_ready drops while stalled or busy.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       aluc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] r_hi,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] r_hi;
      logic             zero;
      logic             carry;
      logic             negative;
      logic             overflow;
      logic             illegal;
   } res_t;

   res_t             res_q;
   res_t             alu_res;
   res_t             mul_res;
   logic             out_valid_q;
   logic             busy_w;
   logic             accept;
   logic             out_take;
   logic             load_alu;
   logic             load_mul;
   logic [WIDTH:0]   add_ext;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   sh;
   logic [SHW-1:0]   sh_m1;
   logic [SHW-1:0]   sh_neg;

   assign in_ready = !busy_w && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_take = out_valid_q && out_ready;

   assign add_ext = {1'b0, a} + {1'b0, b};
   assign diff    = a - b;
   assign sh      = a[SHW-1:0];
   assign sh_m1   = sh - SHW'(1);
   // Index of the last bit shifted out by a left shift: WIDTH-sh, taken modulo WIDTH
   assign sh_neg  = SHW'(0) - sh;

   always_comb begin
      alu_res = '0;
      if (aluc[4]) begin
         alu_res.illegal = 1'b1;
      end else begin
         case (aluc[3:0])
            4'b0000: begin
               alu_res.r     = add_ext[WIDTH-1:0];
               alu_res.carry = add_ext[WIDTH];
            end
            4'b0010: begin
               alu_res.r        = add_ext[WIDTH-1:0];
               alu_res.overflow = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
            end
            4'b0001: begin
               alu_res.r     = diff;
               alu_res.carry = a < b;
            end
            4'b0011: begin
               alu_res.r        = diff;
               alu_res.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            4'b0100: alu_res.r = a & b;
            4'b0101: alu_res.r = a | b;
            4'b0110: alu_res.r = a ^ b;
            4'b0111: alu_res.r = ~(a | b);
            4'b1000, 4'b1001: alu_res.r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b1011: alu_res.r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1010: begin
               alu_res.r     = {{(WIDTH-1){1'b0}}, a < b};
               alu_res.carry = a < b;
            end
            4'b1100: begin
               alu_res.r     = $unsigned($signed(b) >>> sh);
               alu_res.carry = (sh != '0) && b[sh_m1];
            end
            4'b1101: begin
               alu_res.r     = b >> sh;
               alu_res.carry = (sh != '0) && b[sh_m1];
            end
            default: begin
               alu_res.r     = b << sh;
               alu_res.carry = (sh != '0) && b[sh_neg];
            end
         endcase
      end
      alu_res.zero     = (alu_res.r == '0);
      alu_res.negative = alu_res.r[MSB];
   end

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH:0]     part_sum;
   logic               mul_start;

   assign mul_start = accept && (aluc == 5'b10000);
   assign load_alu  = accept && !mul_start;
   assign busy_w    = (state_q != IDLE);
   // Shift-add step: upper half accumulates the multiplicand when the current multiplier bit is set
   assign part_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

   always_comb begin
      state_d  = state_q;
      load_mul = 1'b0;
      case (state_q)
         IDLE: if (mul_start) state_d = RUN;
         RUN:  if (cnt_q == SHW'(WIDTH - 1)) state_d = DONE;
         DONE: begin
            if (!out_valid_q || out_ready) begin
               load_mul = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         if (mul_start) begin
            cnt_q   <= '0;
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
         end else if (state_q == RUN) begin
            cnt_q  <= cnt_q + SHW'(1);
            prod_q <= {part_sum, prod_q[WIDTH-1:1]};
         end
      end
   end

   always_comb begin
      mul_res          = '0;
      mul_res.r        = prod_q[WIDTH-1:0];
      mul_res.r_hi     = prod_q[2*WIDTH-1:WIDTH];
      mul_res.zero     = (prod_q == '0);
      mul_res.carry    = (prod_q[2*WIDTH-1:WIDTH] != '0);
      mul_res.negative = prod_q[2*WIDTH-1];
   end
`else
   assign busy_w   = 1'b0;
   assign load_alu = accept;
   assign load_mul = 1'b0;
   assign mul_res  = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (load_alu) begin
         res_q       <= alu_res;
         out_valid_q <= 1'b1;
      end else if (load_mul) begin
         res_q       <= mul_res;
         out_valid_q <= 1'b1;
      end else if (out_take) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign r         = res_q.r;
   assign r_hi      = res_q.r_hi;
   assign zero      = res_q.zero;
   assign carry     = res_q.carry;
   assign negative  = res_q.negative;
   assign overflow  = res_q.overflow;
   assign illegal   = res_q.illegal;
   assign busy      = busy_w;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases, backpressure stream and randomized stream against a reference model.
// MULTU cases are included when ALU_MUL_EN is defined.
module tb_alu_pipe;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [4:0]   aluc;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] r;
   logic [W-1:0] r_hi;
   logic         zero;
   logic         carry;
   logic         negative;
   logic         overflow;
   logic         illegal;
   logic         busy;

   typedef struct packed {
      logic [W-1:0] r;
      logic [W-1:0] r_hi;
      logic [4:0]   fl;   // {zero, carry, negative, overflow, illegal}
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;
   bit   mon_en  = 1'b0;
   exp_t exp_q[$];

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .r_hi(r_hi), .zero(zero), .carry(carry), .negative(negative),
      .overflow(overflow), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference model: true-width arithmetic, overflow as "exact result does not fit"
   function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        e;
      logic [63:0] t;
      longint      s;
      logic        c;
      logic        v;
      int          sh;
      e  = '0;
      t  = '0;
      c  = 1'b0;
      v  = 1'b0;
      sh = int'(x[4:0]);
      if (op[4]) begin
`ifdef ALU_MUL_EN
         if (op == 5'b10000) begin
            t      = 64'(x) * 64'(y);
            e.r    = t[31:0];
            e.r_hi = t[63:32];
            e.fl   = {t == 64'd0, t[63:32] != 32'd0, t[63], 1'b0, 1'b0};
            return e;
         end
`endif
         e.fl = 5'b10001;
         return e;
      end
      case (op[3:0])
         4'd0: begin t = 64'(x) + 64'(y); e.r = t[31:0]; c = t[32]; end
         4'd2: begin
            s = longint'($signed(x)) + longint'($signed(y));
            e.r = x + y;
            v = (s != longint'($signed(e.r)));
         end
         4'd1: begin e.r = x - y; c = (x < y); end
         4'd3: begin
            s = longint'($signed(x)) - longint'($signed(y));
            e.r = x - y;
            v = (s != longint'($signed(e.r)));
         end
         4'd4: e.r = x & y;
         4'd5: e.r = x | y;
         4'd6: e.r = x ^ y;
         4'd7: e.r = ~(x | y);
         4'd8, 4'd9: e.r = y << 16;
         4'd10: begin e.r = 32'(x < y); c = (x < y); end
         4'd11: e.r = 32'($signed(x) < $signed(y));
         4'd12: begin t = $unsigned($signed({y, 32'h0}) >>> sh); e.r = t[63:32]; c = t[31]; end
         4'd13: begin t = {y, 32'h0} >> sh; e.r = t[63:32]; c = t[31]; end
         default: begin t = {32'h0, y} << sh; e.r = t[31:0]; c = t[32]; end
      endcase
      e.fl = {e.r == 32'd0, c, e.r[31], v, 1'b0};
      return e;
   endfunction

   // Output side: whenever a result is presented it must equal the oldest outstanding expectation
   task automatic mon_step();
      logic [4:0] fl;
      fl = {zero, carry, negative, overflow, illegal};
      if (in_valid && in_ready) exp_q.push_back(model(aluc, a, b));
      if (out_valid) begin
         check("out_has_exp", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            check("s_r", r, exp_q[0].r);
            check("s_r_hi", r_hi, exp_q[0].r_hi);
            check("s_flags", fl, exp_q[0].fl);
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end
         if (!out_ready) check("stall_in_ready", in_ready, 1'b0);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en) mon_step();
   end

   task automatic pick(input bit bp);
      int k;
      logic [W-1:0] corner [5];
      corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      a = $urandom();
      b = $urandom();
      if (bp) begin
         aluc = 5'b00000;
      end else begin
         k = $urandom_range(0, 19);
         if (k < 16)      aluc = 5'(k);
         else if (k < 18) aluc = 5'b10000;
         else             aluc = 5'($urandom_range(17, 31));
         if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 31));
      end
   endtask

   task automatic stream(input string tag, input int n, input bit bp);
      int sent;
      int cyc;
      int n0;
      bit take;
      sent = 0;
      cyc  = 0;
      n0   = n_out;
      mon_en = 1'b1;
      pick(bp);
      in_valid = 1'b1;
      while (sent < n && cyc < 20000) begin
         if (bp) out_ready = !(cyc >= 1 && cyc <= 3);
         else    out_ready = ($urandom_range(0, 9) < 7);
         if (!bp && !in_valid && $urandom_range(0, 3) != 0) begin
            pick(bp);
            in_valid = 1'b1;
         end
         @(negedge clk);
         take = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (take) begin
            sent++;
            in_valid = 1'b0;
            if (sent < n && (bp || $urandom_range(0, 3) != 0)) begin
               pick(bp);
               in_valid = 1'b1;
            end
         end
      end
      check({tag, "_sent"}, sent, n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_delivered"}, n_out - n0, n);
      mon_en = 1'b0;
   endtask

   task automatic run1(input string tag, input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      e = model(op, x, y);
      out_ready = 1'b1;
      aluc = op;
      a = x;
      b = y;
      in_valid = 1'b1;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_latency"}, out_valid, 1'b1);
      check({tag, "_r"}, r, e.r);
      check({tag, "_r_hi"}, r_hi, e.r_hi);
      check({tag, "_flags"}, {zero, carry, negative, overflow, illegal}, e.fl);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d checks done", n_tests);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      aluc = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_r", r, 0);
      check("rst_r_hi", r_hi, 0);
      check("rst_flags", {zero, carry, negative, overflow, illegal}, 5'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);

      run1("add_ovf", 5'b00010, 32'h7FFF_FFFF, 32'h1);
      check("add_ovf_r_const", r, 32'h8000_0000);
      check("add_ovf_vnc", {overflow, negative, carry}, 3'b110);

      run1("subu", 5'b00001, 32'd3, 32'd5);
      check("subu_r_const", r, 32'hFFFF_FFFE);
      check("subu_cv", {carry, overflow}, 2'b10);

      run1("sub_ovf", 5'b00011, 32'h8000_0000, 32'h1);
      check("sub_ovf_r_const", r, 32'h7FFF_FFFF);
      check("sub_ovf_v", overflow, 1'b1);

      run1("sra", 5'b01100, 32'h1, 32'h8000_0001);
      check("sra_r_const", r, 32'hC000_0000);
      check("sra_c", carry, 1'b1);

      run1("sll", 5'b01110, 32'h1, 32'h8000_0000);
      check("sll_zc", {r == 32'd0, zero, carry}, 3'b111);

      run1("ill_10101", 5'b10101, 32'h1234, 32'h5678);
      check("ill_10101_const", {illegal, zero, r, r_hi}, {2'b11, 64'h0});

`ifndef ALU_MUL_EN
      run1("ill_10000", 5'b10000, 32'hFFFF_FFFF, 32'h2);
      check("ill_10000_const", {illegal, zero, r, r_hi}, {2'b11, 64'h0});
      check("nomul_busy", busy, 1'b0);
`else
      begin
         int cnt;
         bit bad;
         aluc = 5'b10000;
         a = 32'hFFFF_FFFF;
         b = 32'h2;
         in_valid = 1'b1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check("mul_busy", busy, 1'b1);
         check("mul_in_ready", in_ready, 1'b0);
         cnt = 1;
         bad = 1'b0;
         while (!out_valid && cnt < 100) begin
            if (in_ready || !busy) bad = 1'b1;
            @(posedge clk);
            #1;
            cnt++;
         end
         check("mul_latency", cnt, W + 1);
         check("mul_busy_hold", bad, 1'b0);
         check("mul_r", r, 32'hFFFF_FFFE);
         check("mul_r_hi", r_hi, 32'h1);
         check("mul_carry", carry, 1'b1);
         check("mul_busy_end", busy, 1'b0);

         @(posedge clk);
         #1;
         aluc = 5'b10000;
         a = 32'hDEAD_BEEF;
         b = 32'h1234_5678;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         repeat (9) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check("mulrst_busy", busy, 1'b0);
         check("mulrst_out_valid", out_valid, 1'b0);
         #2;
         rst_n = 1'b1;
         bad = 1'b0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) bad = 1'b1;
         end
         check("mulrst_no_result", bad, 1'b0);
         run1("after_rst_add", 5'b00010, 32'h0000_0005, 32'hFFFF_FFFD);
      end
`endif

      @(posedge clk);
      #1;
      check("idle_out_valid", out_valid, 1'b0);

      stream("bp", 4, 1'b1);
      stream("rnd", 400, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the single-cycle combinational ALU in the datapath. It accepts one operation per cycle over a valid/ready handshake and returns a registered result with flags. An optional iterative unsigned multiplier produces a 2×WIDTH product. It sits between ID/EX operand latch and EX/MEM, and lets the pipeline stall on a multi-cycle op without external control logic.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8; SHW = $clog2(WIDTH) derived localparam
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A; shift amount is a[SHW-1:0]
- b  in  WIDTH  operand B
- aluc  in  5  opcode; [3:0] keeps legacy encoding, [4]=1 selects multi-cycle ops
- out_valid  out  1  result registers hold a result
- out_ready  in  1  consumer takes result
- r  out  WIDTH  result (low half for MULTU)
- r_hi  out  WIDTH  high half of MULTU product, 0 for all other ops
- zero, carry, negative, overflow  out  1 each  flags
- illegal  out  1  opcode not implemented; result forced 0
- busy  out  1  multiplier FSM active

## Operation
- Opcodes, aluc[4]=0: 0000 ADDU, 0010 ADD, 0001 SUBU, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000/1001 LUI ({b[WIDTH/2-1:0], WIDTH/2 zeros}), 1011 SLT, 1010 SLTU, 1100 SRA, 1101 SRL, 1110/1111 SLL (b shifted by a[SHW-1:0]).
- aluc[4]=1: 10000 MULTU; every other value with [4]=1 is illegal.
- zero = (r==0), and for MULTU ({r_hi,r}==0). negative = r[WIDTH-1], and for MULTU r_hi[WIDTH-1].
- carry: ADDU carry-out. SUBU borrow (a<b unsigned). SLTU = r[0]. Shifts give the last bit shifted out, or 0 when shamt=0. MULTU gives (r_hi!=0). All other ops give 0.
- overflow: ADD when the operand signs are equal and the result sign differs. SUB when the operand signs differ and the result sign differs from a. All other ops give 0.
- No output is ever high-impedance.
- Multiplier FSM:
  - States: IDLE → RUN on MULTU accept. RUN → DONE after WIDTH shift-add iterations. DONE → IDLE when the result is loaded into the output registers.
  - The multiplicand and multiplier are latched on accept.

## Timing
- Reset: out_valid=0, r=0, r_hi=0, all flags=0, illegal=0, busy=0, FSM=IDLE, in_ready=1 on the first cycle after deassertion.
- in_ready = !busy && (!out_valid || out_ready).
- Transfer occurs on an edge where in_valid && in_ready. Transfer out occurs on an edge where out_valid && out_ready.
- Single-cycle ops: result and flags are registered on the accept edge. out_valid is 1 on the next cycle. Throughput is 1 op/cycle with out_ready held high.
- MULTU:
  - busy=1 from the accept edge until the result is loaded.
  - out_valid rises WIDTH+1 cycles after the accept edge.
  - in_ready=0 throughout.
- Backpressure: while out_valid && !out_ready, r/r_hi/flags are held stable and in_ready=0.
- A DONE state with a blocked output waits in DONE.
- Simultaneous out-transfer and in-transfer on one edge: the new result replaces the old, and out_valid stays 1.
- Reset assertion mid-MULTU aborts the op immediately. No result is emitted.
- in_valid while in_ready=0 is ignored. The producer must hold its inputs.

## Configuration
- ALU_MUL_EN defined: the MULTU FSM and datapath are compiled in.
- ALU_MUL_EN undefined:
  - No FSM; busy is tied 0.
  - aluc=10000 is treated as illegal: 1-cycle latency, r=r_hi=0, zero=1, other flags 0, illegal=1.

## Test plan
- WIDTH=32: ADD a=0x7FFFFFFF, b=1 → r=0x80000000, overflow=1, negative=1, carry=0, out_valid next cycle.
- SUBU a=3, b=5 → r=0xFFFFFFFE, carry=1, overflow=0. SUB a=0x80000000, b=1 → r=0x7FFFFFFF, overflow=1.
- SRA b=0x80000001, a=1 → r=0xC0000000, carry=1. SLL b=0x80000000, a=1 → r=0, zero=1, carry=1.
- Backpressure: 4 back-to-back ADDUs with out_ready low for cycles 2–4 → results delivered in order, unchanged while held, in_ready=0 while stalled, no op lost.
- With ALU_MUL_EN defined: MULTU a=0xFFFFFFFF, b=2 → r=0xFFFFFFFE, r_hi=1, carry=1, out_valid at accept+33. Reset pulse at accept+10 → busy=0, out_valid=0, and the next ADD completes normally.
- Without ALU_MUL_EN: aluc=10000 → illegal=1, r=0, zero=1, one-cycle latency. aluc=10101 gives the same with either build.
